serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor computing D = A − B − b_in, one bit per clock, LSB first. It is the inverse-direction companion to the team's parallel ripple-carry adder. It trades N cycles of latency for a single full-subtractor cell, and sits behind a valid/ready handshake on both input and output so it can be dropped into streaming datapaths.

## Interface
- N, default 8: operand and result width in bits; legal range N ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; synchronous deassertion is the integrator's responsibility.
- in_valid  input  1  operands A, B, b_in are valid.
- in_ready  output  1  block can accept operands.
- A  input  N  minuend.
- B  input  N  subtrahend.
- b_in  input  1  borrow in.
- out_valid  output  1  D, b_out (and ovf) are valid.
- out_ready  input  1  downstream accepts the result.
- D  output  N  difference, A − B − b_in mod 2^N.
- b_out  output  1  borrow out; 1 iff A < B + b_in as unsigned values.
- ovf  output  1  signed overflow; present only with SUB_OVERFLOW_EN.

## Operation
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0.
  - RUN: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- IDLE:
  - Accept occurs when in_valid & in_ready at a clock edge.
  - On accept, capture A into a shift register, B into a shift register, and b_in into the borrow flop.
  - Clear the bit counter and go to RUN.
- RUN, every edge:
  - a = A_sr[0], b = B_sr[0], br = borrow flop.
  - d = a ^ b ^ br.
  - Next borrow = (~a & b) | (~(a ^ b) & br).
  - Shift d into D_sr from the MSB side (right shift), then shift A_sr and B_sr right.
  - Increment the counter.
  - After the N-th RUN edge, go to DONE.
- DONE:
  - D = D_sr and b_out = final borrow, both held stable while out_valid = 1.
  - When out_valid & out_ready at an edge, go to IDLE.
- A, B, b_in, and in_valid are ignored outside IDLE.
- in_ready is a function of state only and has no combinational path from out_ready.
- D and b_out hold their last value after the handshake until the next result is loaded. Observers must qualify them with out_valid.

## Timing
- Reset values (asserted asynchronously):
  - State = IDLE.
  - in_ready = 1.
  - out_valid = 0.
  - D = 0, b_out = 0, ovf = 0.
  - Counter and shift registers = 0.
- Latency: with acceptance at edge t0, out_valid rises after edge t0+N.
- Minimum initiation interval is N+2 cycles: N RUN edges, 1 DONE edge with out_ready = 1, then IDLE accepts on the next edge.
- Backpressure: DONE persists indefinitely while out_ready = 0, with outputs stable.
- out_ready asserted before DONE has no effect.
- Reset mid-operation (RUN or DONE): the operation is discarded, no out_valid pulse is produced, and the block is in IDLE with in_ready = 1 immediately.
- Counter width is clog2(N+1). The counter never wraps within an operation.

## Configuration
- SUB_OVERFLOW_EN defined:
  - ovf port exists.
  - The MSBs of A and B are latched at accept.
  - In DONE, ovf = (A[N-1] ≠ B[N-1]) & (D[N-1] ≠ A[N-1]).
  - ovf is valid with out_valid and its reset value is 0.
- SUB_OVERFLOW_EN undefined: no ovf port and no extra flops. All other behaviour is identical.

## Test plan
- N=8, A=0x5A, B=0x23, b_in=0: D=0x37, b_out=0; out_valid rises exactly 8 edges after acceptance; in_ready=0 throughout.
- Borrow paths:
  - A=0x00, B=0x01, b_in=0: D=0xFF, b_out=1.
  - A=0x10, B=0x10, b_in=1: D=0xFF, b_out=1.
  - A=0x10, B=0x0F, b_in=1: D=0x00, b_out=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands. D/b_out stay stable, in_ready=0, and the second op is not accepted until 1 edge after out_ready=1.
- Assert rst_n low at the 3rd RUN edge, then release. Required: out_valid=0, in_ready=1, D=0. The next op A=0xFF, B=0x0F then gives D=0xF0, b_out=0.
- Back-to-back: 100 random ops with out_ready tied to 1, checked against A−B−b_in in a reference model. Every issue-to-issue interval is exactly N+2 cycles.
- SUB_OVERFLOW_EN:
  - A=0x80, B=0x01: D=0x7F, ovf=1, b_out=0.
  - A=0x7F, B=0xFF: D=0x80, ovf=1, b_out=1.
  - A=0x05, B=0x03: ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor D = A - B - b_in, LSB first, behind valid/ready handshakes.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] D,
  output logic         b_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_a_sr;
  logic [N-1:0]  r_b_sr;
  logic [N-1:0]  r_d_sr;
  logic [N-1:0]  r_d;
  logic          r_borrow;
  logic          r_b_out;
  logic [CW-1:0] r_cnt;
  logic          w_a;
  logic          w_b;
  logic          w_d;
  logic          w_borrow_next;
  logic          w_last;

  // Single full-subtractor cell working on the current LSBs.
  assign w_a           = r_a_sr[0];
  assign w_b           = r_b_sr[0];
  assign w_d           = w_a ^ w_b ^ r_borrow;
  assign w_borrow_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
  assign w_last        = (r_state == RUN) && (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (r_cnt == CW'(N - 1)) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Result registers are loaded only on the final RUN edge so D/b_out stay
  // stable through DONE and after the handshake until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_d_sr   <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_b_out  <= 1'b0;
      r_cnt    <= '0;
    end else if ((r_state == IDLE) && in_valid) begin
      r_a_sr   <= A;
      r_b_sr   <= B;
      r_borrow <= b_in;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a_sr   <= {1'b0, r_a_sr[N-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[N-1:1]};
      r_d_sr   <= {w_d, r_d_sr[N-1:1]};
      r_borrow <= w_borrow_next;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_d     <= {w_d, r_d_sr[N-1:1]};
        r_b_out <= w_borrow_next;
      end
    end
  end

  assign D     = r_d;
  assign b_out = r_b_out;

`ifdef SUB_OVERFLOW_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // The last computed bit is the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if ((r_state == IDLE) && in_valid) begin
      r_a_msb <= A[N-1];
      r_b_msb <= B[N-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: arithmetic reference model, queue of expected
// results, and a monitor that checks every output handshake.
module tb_serial_subtractor;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         b_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] D;
  logic         b_out;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .b_out(b_out)
`ifdef SUB_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors  = 0;
  int   checks  = 0;
  int   results = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer subtraction; ovf uses the sign-disagreement rule.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    exp_t m;
    int   diff;
    diff   = int'(a) - int'(b) - int'(bi);
    m.d    = diff[N-1:0];
    m.bout = (diff < 0);
    m.ovf  = (a[N-1] != b[N-1]) && (m.d[N-1] != a[N-1]);
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result_D", D, 32'hDEAD_BEEF);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_D", D, mon_e.d);
        chk("sb_b_out", b_out, mon_e.bout);
`ifdef SUB_OVERFLOW_EN
        chk("sb_ovf", ovf, mon_e.ovf);
`endif
        $display("result %0d: D=%0h b_out=%0b", results, D, b_out);
      end
      results++;
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi, output int t_acc);
    int guard;
    guard    = 0;
    A        = a;
    B        = b;
    b_in     = bi;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      t_acc    = -1;
      return;
    end
    sb_q.push_back(model(a, b, bi));
    t_acc = cyc + 1;
    $display("issue A=%0h B=%0h b_in=%0b at edge %0d", a, b, bi, t_acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target);
    int guard;
    guard = 0;
    while (results < target && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("result_timeout", (results >= target), 1);
  endtask

  task automatic run_dir(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi,
                         input logic [N-1:0] exp_d, input logic exp_b);
    int base;
    int t;
    base = results;
    issue(a, b, bi, t);
    wait_results(base + 1);
    chk("dir_D", D, exp_d);
    chk("dir_b_out", b_out, exp_b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int prev;
    int base;
    int guard;
    int hs_edge;

    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    b_in      = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_D", D, 0);
    chk("rst_b_out", b_out, 0);
`ifdef SUB_OVERFLOW_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: out_valid rises exactly N edges after acceptance.
    issue(8'h5A, 8'h23, 1'b0, t);
    for (int k = 1; k < N; k++) begin
      @(posedge clk); #1;
      chk("lat_out_valid", out_valid, 0);
      chk("lat_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    chk("lat_out_valid_rise", out_valid, 1);
    chk("lat_in_ready_done", in_ready, 0);
    chk("lat_D", D, 8'h37);
    chk("lat_b_out", b_out, 0);
    out_ready = 1'b1;
    wait_results(1);

    run_dir(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_dir(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    run_dir(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);

`ifdef SUB_OVERFLOW_EN
    run_dir(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    chk("ovf_80_01", ovf, 1);
    run_dir(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1);
    chk("ovf_7F_FF", ovf, 1);
    run_dir(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    chk("ovf_05_03", ovf, 0);
`endif

    // Backpressure: hold DONE with new operands offered on the input.
    out_ready = 1'b0;
    base      = results;
    issue(8'hC3, 8'h3C, 1'b1, t);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("bp_valid_timeout", out_valid, 1);
    A        = 8'h11;
    B        = 8'h22;
    b_in     = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_D", D, 8'h86);
      chk("bp_b_out", b_out, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    hs_edge = cyc;
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    issue(8'h11, 8'h22, 1'b0, t);
    chk("bp_accept_edge", t, hs_edge + 1);
    wait_results(base + 2);
    chk("bp_second_D", D, 8'hEF);

    // Reset in the middle of RUN discards the operation.
    issue(8'h12, 8'h34, 1'b0, t);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_D", D, 0);
    chk("mid_rst_b_out", b_out, 0);
    sb_q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (N + 3) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", out_valid, 0);
    end
    run_dir(8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0);

    // Back-to-back random traffic with fixed initiation interval.
    out_ready = 1'b1;
    base      = results;
    prev      = -1;
    for (int i = 0; i < 100; i++) begin
      issue(N'($urandom), N'($urandom), 1'($urandom), t);
      if (prev >= 0) chk("initiation_interval", t - prev, N + 2);
      prev = t;
    end
    wait_results(base + 100);
    chk("queue_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
